// File: rtl/seq_bit_scheduler.sv
// Press-capture bit FIFO feeding a tick-paced issue FSM for a 110 detector.
// Counts detector hits (saturating) and flags dropped presses (sticky).
module seq_bit_scheduler #(
    parameter int TICK_DIV = 49_000_000,
    parameter int DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       in1,
    input  logic       in0,
    input  logic       det_in,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic [7:0] match_count,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TDIV_C  = TW'(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ISSUE,
        SETTLE
    } state_t;

    state_t          state_q;
    logic            in1_q, in0_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, full_q;
    logic            bit_out_q, bit_valid_q;
    logic [7:0]      match_q;
    logic            ovf_q;

    logic press1, press0, push, push_ok, drop;
    logic tick, has_data, pop;

    always_comb begin
        press1   = in1 & ~in1_q;
        press0   = in0 & ~in0_q;
        push     = press1 ^ press0;
        tick     = (tcnt_q == TDIV_C);
        tcnt_d   = tick ? '0 : tcnt_q + TW'(1);
        has_data = (count_q != '0);
        pop      = (state_q == ARMED) && run && tick && has_data;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push_ok  = push && ((count_q != DEPTH_C) || pop);
        drop     = push && !push_ok;
        count_d  = count_q;
        if (push_ok && !pop)
            count_d = count_q + CW'(1);
        else if (!push_ok && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            in1_q       <= 1'b0;
            in0_q       <= 1'b0;
            tcnt_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            match_q     <= 8'd0;
            ovf_q       <= 1'b0;
        end else begin
            in1_q       <= in1;
            in0_q       <= in0;
            tcnt_q      <= tcnt_d;
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DEPTH_C);
            bit_valid_q <= 1'b0;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= press1;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop)
                ovf_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (run && has_data)
                        state_q <= ARMED;
                end
                ARMED: begin
                    if (!run) begin
                        state_q <= IDLE;
                    end else if (pop) begin
                        bit_out_q   <= mem_q[rd_ptr_q];
                        bit_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    // Detector has advanced on the strobe; its flag is current.
                    if (det_in && match_q != 8'hFF)
                        match_q <= match_q + 8'd1;
                    state_q <= (run && has_data) ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign fifo_empty  = empty_q;
    assign fifo_full   = full_q;
    assign match_count = match_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_bit_scheduler.sv
// Randomised bench for seq_bit_scheduler with a queue model of the FIFO
// and a last-three-bits model of the downstream 110 detector.
module tb_seq_bit_scheduler;

    logic       clk = 1'b0;
    logic       rst, run, in1, in0, det_in;
    logic       bit_out, bit_valid, fifo_empty, fifo_full, overflow;
    logic [7:0] match_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    bit sq[$];
    int scyc[$];
    bit mq[$];
    logic [2:0] hist;
    logic force_det;

    seq_bit_scheduler #(.TICK_DIV(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .run(run), .in1(in1), .in0(in0),
        .det_in(det_in), .bit_out(bit_out), .bit_valid(bit_valid),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .match_count(match_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Moore 110 detector: flags when the last three bits seen were 1,1,0
    always @(posedge clk)
        if (!rst) hist <= 3'b000;
        else if (bit_valid) hist <= {hist[1:0], bit_out};

    assign det_in = force_det | (hist == 3'b110);

    always @(negedge clk)
        if (bit_valid === 1'b1) begin
            sq.push_back(bit_out);
            scyc.push_back(cyc);
        end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; in1 = 1'b0; in0 = 1'b0; force_det = 1'b0;
        step(2);
        rst = 1'b1;
        sq.delete(); scyc.delete(); mq.delete();
    endtask

    task automatic press(input bit b);
        if (b) in1 = 1'b1; else in0 = 1'b1;
        step(1);
        in1 = 1'b0; in0 = 1'b0;
        step(1);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && sq.size() < n; i++) step(1);
    endtask

    function automatic int hits110(input int dummy);
        int h = 0;
        for (int i = 2; i < mq.size(); i++)
            if (mq[i-2] && mq[i-1] && !mq[i]) h++;
        return (h > 255) ? 255 : h + dummy;
    endfunction

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; in1 = 1'b0; in0 = 1'b0; force_det = 1'b0;
        step(1);
        in1 = 1'b1;
        step(2);
        in1 = 1'b0;
        n_cmp++; if (bit_out !== 1'b0) begin n_err++; $display("FAIL rst_bit_out got %b want 0", bit_out); end
        n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rst_bit_valid got %b want 0", bit_valid); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", fifo_full); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL rst_match got %0d want 0", match_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
        rst = 1'b1; run = 1'b0;
        step(3);
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_nopush got empty=%b want 1", fifo_empty); end
    endtask

    task automatic test_basic();
        do_reset();
        run = 1'b1;
        press(1); press(1); press(0);
        wait_strobes(3, 40);
        step(4);
        n_cmp++; if (sq.size() !== 3) begin n_err++; $display("FAIL basic_count got %0d want 3", sq.size()); end
        if (sq.size() >= 3) begin
            n_cmp++; if ({sq[0], sq[1], sq[2]} !== 3'b110) begin n_err++; $display("FAIL basic_bits got %b%b%b want 110", sq[0], sq[1], sq[2]); end
            n_cmp++; if (scyc[1] - scyc[0] !== 4 || scyc[2] - scyc[1] !== 4) begin n_err++; $display("FAIL basic_gap got %0d,%0d want 4,4", scyc[1] - scyc[0], scyc[2] - scyc[1]); end
        end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL basic_match got %0d want 1", match_count); end
    endtask

    task automatic test_overflow();
        bit pat[5] = '{1, 0, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(pat[i]);
            if (i < 4) mq.push_back(pat[i]);
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        run = 1'b1;
        wait_strobes(4, 60);
        step(20);
        n_cmp++; if (sq.size() !== 4) begin n_err++; $display("FAIL ovf_strobes got %0d want 4", sq.size()); end
        n_cmp++; if (sq !== mq) begin n_err++; $display("FAIL ovf_order got %p want %p", sq, mq); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained got %b want 1", fifo_empty); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run = 1'b1;
        in1 = 1'b1; in0 = 1'b1;
        step(3);
        in1 = 1'b0; in0 = 1'b0;
        step(12);
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL simul_empty got %b want 1", fifo_empty); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf got %b want 0", overflow); end
        n_cmp++; if (sq.size() !== 0) begin n_err++; $display("FAIL simul_strobes got %0d want 0", sq.size()); end
    endtask

    task automatic test_full_pop();
        int k;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mq.push_back(1'($urandom_range(0, 1)));
            press(mq[i]);
        end
        run = 1'b1;
        k = 0;
        while (bit_valid !== 1'b1 && k < 40) begin step(1); k++; end
        n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL fullpop_first got timeout want strobe"); end
        // refill to four, then press exactly in the next pop cycle
        step(1); in0 = 1'b1; mq.push_back(1'b0);
        step(1); in0 = 1'b0;
        step(1); in1 = 1'b1; mq.push_back(1'b1);
        step(1); in1 = 1'b0;
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fullpop_full got %b want 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        wait_strobes(6, 80);
        step(6);
        n_cmp++; if (sq !== mq) begin n_err++; $display("FAIL fullpop_order got %p want %p", sq, mq); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL fullpop_drained got %b want 1", fifo_empty); end
    endtask

    task automatic test_saturate();
        do_reset();
        force_det = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 300; i++) begin
            press(1'($urandom_range(0, 1)));
            step(2);
        end
        wait_strobes(300, 100);
        step(6);
        n_cmp++; if (sq.size() !== 300) begin n_err++; $display("FAIL sat_strobes got %0d want 300", sq.size()); end
        n_cmp++; if (match_count !== 8'd255) begin n_err++; $display("FAIL sat_match got %0d want 255", match_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sat_ovf got %b want 0", overflow); end
    endtask

    task automatic test_random();
        bit b;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                in1 = 1'b1; in0 = 1'b1;
                step(1);
                in1 = 1'b0; in0 = 1'b0;
                step(1);
            end else begin
                b = 1'($urandom_range(0, 1));
                mq.push_back(b);
                press(b);
            end
            step($urandom_range(2, 6));
        end
        wait_strobes(mq.size(), 80);
        step(6);
        n_cmp++; if (sq !== mq) begin n_err++; $display("FAIL rand_order got %p want %p", sq, mq); end
        n_cmp++; if (match_count !== 8'(hits110(0))) begin n_err++; $display("FAIL rand_match got %0d want %0d", match_count, hits110(0)); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rand_ovf got %b want 0", overflow); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rand_drained got %b want 1", fifo_empty); end
    endtask

    task automatic test_reset_issue();
        int k;
        do_reset();
        press(1); press(0); press(1);
        run = 1'b1;
        k = 0;
        while (bit_valid !== 1'b1 && k < 40) begin step(1); k++; end
        n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL rsti_strobe got timeout want strobe"); end
        rst = 1'b0;
        step(1);
        n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rsti_valid got %b want 0", bit_valid); end
        n_cmp++; if (bit_out !== 1'b0) begin n_err++; $display("FAIL rsti_bit_out got %b want 0", bit_out); end
        n_cmp++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin n_err++; $display("FAIL rsti_status got e=%b f=%b want e=1 f=0", fifo_empty, fifo_full); end
        n_cmp++; if (match_count !== 8'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL rsti_cnt got m=%0d o=%b want 0 0", match_count, overflow); end
        rst = 1'b1;
        sq.delete();
        step(20);
        n_cmp++; if (sq.size() !== 0) begin n_err++; $display("FAIL rsti_quiet got %0d strobes want 0", sq.size()); end
        press(0);
        wait_strobes(1, 30);
        n_cmp++; if (sq.size() !== 1 || sq[0] !== 1'b0) begin n_err++; $display("FAIL rsti_new got n=%0d want one 0 strobe", sq.size()); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        step(1);
        test_reset();
        test_basic();
        test_overflow();
        test_simultaneous();
        test_full_pop();
        test_random();
        test_saturate();
        test_reset_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
